// File: rtl/lighting_system.sv
// Smart-home shade and lamp controller with registered outputs.
// Define LIGHTING_RAMP_EN for +/-1 per cycle soft dimming; otherwise targets load directly.
module lighting_system (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  tcode,
    input  logic [3:0]  ulight,
    input  logic [3:0]  lenght,
    output logic [3:0]  wshade,
    output logic [3:0]  lightnum,
    output logic [15:0] lightstate
);

    logic       valid;
    logic [3:0] shade_tgt;
    logic [3:0] base;
    logic [4:0] sum;
    logic [3:0] light_tgt;
    logic [3:0] ws_nxt;
    logic [3:0] ln_nxt;

    function automatic logic [15:0] therm(input logic [3:0] n);
        therm = 16'((17'd1 << n) - 17'd1);
    endfunction

    always_comb begin
        valid     = (tcode != 4'd0) && ((tcode & (tcode - 4'd1)) == 4'd0);
        shade_tgt = wshade;
        base      = 4'd0;
        if (valid) begin
            unique case (1'b1)
                tcode[0]: shade_tgt = 4'd15;
                tcode[1]: shade_tgt = 4'd8;
                tcode[2]: begin
                    shade_tgt = 4'd4;
                    base      = lenght >> 1;
                end
                tcode[3]: begin
                    shade_tgt = 4'd0;
                    base      = lenght;
                end
                default: ;
            endcase
        end
        // 5-bit sum so base + ulight cannot wrap before saturating to N
        sum       = {1'b0, base} + {1'b0, ulight};
        light_tgt = (sum > {1'b0, lenght}) ? lenght : sum[3:0];
    end

`ifdef LIGHTING_RAMP_EN
    always_comb begin
        ws_nxt = wshade;
        ln_nxt = lightnum;
        if (wshade < shade_tgt)
            ws_nxt = wshade + 4'd1;
        else if (wshade > shade_tgt)
            ws_nxt = wshade - 4'd1;
        if (lightnum < light_tgt)
            ln_nxt = lightnum + 4'd1;
        else if (lightnum > light_tgt)
            ln_nxt = lightnum - 4'd1;
    end
`else
    always_comb begin
        ws_nxt = shade_tgt;
        ln_nxt = light_tgt;
    end
`endif

    // Invalid time codes freeze both shade and lamps
    always_ff @(posedge clk) begin
        if (rst) begin
            wshade     <= 4'd0;
            lightnum   <= 4'd0;
            lightstate <= 16'h0000;
        end else if (valid) begin
            wshade     <= ws_nxt;
            lightnum   <= ln_nxt;
            lightstate <= therm(ln_nxt);
        end
    end

endmodule

// File: tb/tb_lighting_system.sv
// Bench for lighting_system: behavioural model compared every cycle,
// directed test-plan checks with literal values, then random stimulus.
module tb_lighting_system;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  tcode = 4'd0;
    logic [3:0]  ulight = 4'd0;
    logic [3:0]  lenght = 4'd0;
    logic [3:0]  wshade;
    logic [3:0]  lightnum;
    logic [15:0] lightstate;

    int total = 0;
    int bad = 0;
    bit chk_en = 0;

    int m_ws = 0;
    int m_ln = 0;

    lighting_system dut (
        .clk(clk),
        .rst(rst),
        .tcode(tcode),
        .ulight(ulight),
        .lenght(lenght),
        .wshade(wshade),
        .lightnum(lightnum),
        .lightstate(lightstate)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lamp_map(input int n);
        int m = 0;
        for (int i = 0; i < 16; i++)
            if (i < n) m = m | (1 << i);
        return m;
    endfunction

    // Reference model from the mode table
    always @(posedge clk) begin
        int st, b, t;
        if (rst) begin
            m_ws = 0;
            m_ln = 0;
        end else if (tcode == 1 || tcode == 2 || tcode == 4 || tcode == 8) begin
            case (tcode)
                4'd1: begin st = 15; b = 0; end
                4'd2: begin st = 8; b = 0; end
                4'd4: begin st = 4; b = int'(lenght) / 2; end
                default: begin st = 0; b = int'(lenght); end
            endcase
            t = b + int'(ulight);
            if (t > int'(lenght)) t = int'(lenght);
`ifdef LIGHTING_RAMP_EN
            if (m_ws < st) m_ws++;
            else if (m_ws > st) m_ws--;
            if (m_ln < t) m_ln++;
            else if (m_ln > t) m_ln--;
`else
            m_ws = st;
            m_ln = t;
`endif
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("wshade", int'(wshade), m_ws);
            chk("lightnum", int'(lightnum), m_ln);
            chk("lightstate", int'(lightstate), lamp_map(m_ln));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic [3:0] t, input logic [3:0] u, input logic [3:0] l);
        tcode = t;
        ulight = u;
        lenght = l;
    endtask

    task automatic lit(input string name, input int ws, input int ln, input int ls);
        chk({name, ".ws"}, int'(wshade), ws);
        chk({name, ".ln"}, int'(lightnum), ln);
        chk({name, ".ls"}, int'(lightstate), ls);
    endtask

    initial begin
        cyc(2);
        chk_en = 1;
        lit("reset", 0, 0, 0);
        rst = 1'b0;
        drive(4'b0001, 4'd2, 4'd4);
`ifdef LIGHTING_RAMP_EN
        cyc(14);
        chk("ramp14", int'(wshade), 14);
        cyc(1);
`else
        cyc(1);
`endif
        lit("morning", 15, 2, 16'h0003);
        drive(4'b0010, 4'd2, 4'd4);
`ifdef LIGHTING_RAMP_EN
        cyc(7);
`else
        cyc(1);
`endif
        lit("noon", 8, 2, 16'h0003);
        drive(4'b0100, 4'd2, 4'd4);
        cyc(5);
        lit("evening", 4, 4, 16'h000F);
        drive(4'b1000, 4'd4, 4'd4);
        cyc(5);
        lit("night", 0, 4, 16'h000F);
        drive(4'b1000, 4'd15, 4'd15);
        cyc(12);
        lit("nightmax", 0, 15, 16'h7FFF);
        drive(4'b0011, 4'd0, 4'd0);
        cyc(4);
        lit("invalid", 0, 15, 16'h7FFF);
        drive(4'b1000, 4'd15, 4'd1);
        cyc(15);
        lit("shrink", 0, 1, 16'h0001);
        drive(4'b1000, 4'd15, 4'd0);
        cyc(2);
        lit("zero", 0, 0, 16'h0000);
        drive(4'b0001, 4'd3, 4'd9);
        cyc(5);
        rst = 1'b1;
        cyc(1);
        lit("midreset", 0, 0, 16'h0000);
        rst = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 5) == 0)
                    tcode = 4'($urandom_range(0, 15));
                else
                    tcode = 4'(1 << $urandom_range(0, 3));
            end
            if ($urandom_range(0, 9) == 0) ulight = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) lenght = 4'($urandom_range(0, 15));
            cyc(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
